// File: rtl/signex_pkg.sv
// Shared datapath constants for the immediate path.
package signex_pkg;

  // Width of the instruction immediate field.
  localparam int unsigned IMM_W  = 16;
  // Width of a datapath word.
  localparam int unsigned WORD_W = 32;

endpackage : signex_pkg

// File: rtl/signex.sv
// Registered sign-extension of an instruction immediate to a datapath word.
module signex
  import signex_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  // The replicate count below is only meaningful when the output is wider.
  if (OUT_W <= IN_W) begin : g_width_check
    $fatal(1, "signex: OUT_W (%0d) must be greater than IN_W (%0d)", OUT_W, IN_W);
  end

  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;

  // Replicate the sign bit into the upper bits; lower bits copy the input.
  always_comb begin
    out_d = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
  end

  // Output register, cleared asynchronously while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : signex

// File: tb/tb_signex.sv
// Self-checking bench for signex: directed cases plus randomized inputs.
module tb_signex;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [31:0] out;

  int unsigned checks;
  int unsigned errors;

  signex #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: numeric value of the signed 16-bit input, as a 32-bit word.
  function automatic logic [31:0] model(input logic [15:0] v);
    shortint s;
    int      w;
    s = shortint'(v);
    w = int'(s);
    return 32'(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive v after a falling edge, then check one step after the next rising edge.
  task automatic step(input string tag, input logic [15:0] v, input logic [31:0] exp);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] w;
    logic [31:0] held;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    in     = 16'h8001;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 chk("reset_no_clock", out, 32'h0000_0000);
    // Held in reset across edges regardless of input.
    @(posedge clk); #1 chk("reset_held", out, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 chk("release_first_edge", out, 32'hFFFF_8001);

    step("pos_one", 16'h0001, 32'h0000_0001);
    // Input change between edges does not reach the output.
    @(negedge clk);
    in = 16'h8001;
    #1 chk("hold_between_edges", out, 32'h0000_0001);
    @(posedge clk); #1 chk("neg_8001", out, 32'hFFFF_8001);

    step("max_pos", 16'h7FFF, 32'h0000_7FFF);
    step("min_neg", 16'h8000, 32'hFFFF_8000);
    step("minus_one", 16'hFFFF, 32'hFFFF_FFFF);
    step("zero", 16'h0000, 32'h0000_0000);

    // Two writes within one cycle: only the sampled value matters.
    @(negedge clk);
    in = 16'h1234;
    #1 in = 16'h99FF;
    #1 chk("double_write_hold", out, 32'h0000_0000);
    @(posedge clk); #1 chk("double_write_load", out, 32'hFFFF_99FF);
    @(posedge clk); #1 chk("stable_next_edge", out, 32'hFFFF_99FF);

    // Mid-cycle reset clears without a clock edge, reload after release.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_clear", out, 32'h0000_0000);
    @(posedge clk); #1 chk("clear_held", out, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after_release_no_edge", out, 32'h0000_0000);
    @(posedge clk); #1 chk("reload_after_release", out, 32'hFFFF_99FF);

    // Randomized inputs with intra-cycle glitches on in.
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom);
      w = 16'($urandom);
      step("rand_load", v, model(v));
      held = model(v);
      @(negedge clk);
      in = w;
      #1 chk("rand_hold", out, held);
      @(posedge clk); #1 chk("rand_glitch_load", out, model(w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_signex
